// File: rtl/ins_exec_store_unit_pkg.sv
// Shared decode constants, drain-state encoding and the access-size byte mask.
package ins_exec_store_unit_pkg;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_SB = 3'd0;
  localparam logic [2:0] FUNCT3_SH = 3'd1;
  localparam logic [2:0] FUNCT3_SW = 3'd2;
  localparam logic [2:0] FUNCT3_SD = 3'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } drain_state_t;

  // funct3[1:0] encodes log2 of the access size in bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ins_exec_store_unit_if.sv
// Data-memory port of the store unit: optional read phase (RMW) and a write phase,
// each a request held until its ack.
interface ins_exec_store_unit_if #(
  parameter int XLEN = 32
);
  logic              mem_r_op;
  logic [XLEN-1:0]   mem_r_addr;
  logic              mem_r_ack;
  logic [XLEN-1:0]   mem_r_val;
  logic              mem_w_op;
  logic [XLEN-1:0]   mem_w_mem_addr;
  logic [XLEN-1:0]   mem_w_mem_val;
  logic [XLEN/8-1:0] mem_w_mem_be;
  logic              mem_w_ack;

  modport master (
    output mem_r_op, mem_r_addr,
    input  mem_r_ack, mem_r_val,
    output mem_w_op, mem_w_mem_addr, mem_w_mem_val, mem_w_mem_be,
    input  mem_w_ack
  );

  modport slave (
    input  mem_r_op, mem_r_addr,
    output mem_r_ack, mem_r_val,
    input  mem_w_op, mem_w_mem_addr, mem_w_mem_val, mem_w_mem_be,
    output mem_w_ack
  );
endinterface

// File: rtl/ins_exec_store_unit_store_queue_fifo.sv
// Generic synchronous FIFO, registered count; head is combinational from the read pointer.
// Push is ignored when full and pop when empty; full only drops the cycle after a pop.
module store_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ins_exec_store_unit.sv
// Store executor: decodes/aligns stores, queues them and drains to memory (RMW or byte-enable).
// First memory request two cycles after issue; ready drops when the queue holds DEPTH entries.
module ins_exec_store_unit
  import ins_exec_store_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int USE_BE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op,
  input  logic [6:0]            ins_dec_op,
  input  logic [2:0]            ins_dec_funct3,
  input  logic [XLEN-1:0]       reg_rs1_val,
  input  logic [XLEN-1:0]       reg_rs2_val,
  input  logic [XLEN-1:0]       imm_ext_ext,
  output logic                  ready,
  output logic                  misalign,
  output logic                  empty,
  ins_exec_store_unit_if.master mem
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] dat;
    logic [NB-1:0]   be;
  } entry_t;

  function automatic logic [XLEN-1:0] lane_bits(input logic [NB-1:0] b);
    logic [XLEN-1:0] m;
    for (int i = 0; i < NB; i++) begin
      m[8*i +: 8] = {8{b[i]}};
    end
    return m;
  endfunction

  logic            is_store;
  logic            mis;
  logic            enq;
  logic [XLEN-1:0] addr;
  logic [OW-1:0]   off;
  logic [NB-1:0]   enq_be;
  entry_t          enq_entry;
  entry_t          head;
  logic            q_full;
  logic            q_empty;
  logic            pop;
  logic            misalign_q;
  logic [XLEN-1:0] merged_q;
  drain_state_t    state_q;
  drain_state_t    state_d;

  assign addr = reg_rs1_val + imm_ext_ext;
  assign off  = addr[OW-1:0];

  always_comb begin
    is_store = 1'b0;
    if (op && ins_dec_op == OPCODE_STORE) begin
      is_store = (ins_dec_funct3 == FUNCT3_SB) || (ins_dec_funct3 == FUNCT3_SH) ||
                 (ins_dec_funct3 == FUNCT3_SW) ||
                 ((XLEN == 64) && (ins_dec_funct3 == FUNCT3_SD));
    end
  end

  always_comb begin
    mis = 1'b0;
    case (ins_dec_funct3)
      FUNCT3_SH: mis = off[0];
      FUNCT3_SW: mis = |off[1:0];
      FUNCT3_SD: mis = |off;
      default:   mis = 1'b0;
    endcase
  end

  assign ready  = !q_full;
  assign enq    = is_store && !mis && ready;
  assign enq_be = NB'(size_mask(ins_dec_funct3[1:0])) << off;

  // Data is pre-shifted into its lanes and masked, so it is usable as-is in byte-enable mode.
  always_comb begin
    enq_entry.addr = {addr[XLEN-1:OW], {OW{1'b0}}};
    enq_entry.dat  = (reg_rs2_val << {off, 3'b000}) & lane_bits(enq_be);
    enq_entry.be   = enq_be;
  end

  store_queue_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .push_dat (enq_entry),
    .pop      (pop),
    .full     (q_full),
    .empty    (q_empty),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      misalign_q <= 1'b0;
      merged_q   <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= is_store && mis;
      if (state_q == RD_REQ && mem.mem_r_ack) begin
        merged_q <= (mem.mem_r_val & ~lane_bits(head.be)) | (head.dat & lane_bits(head.be));
      end
    end
  end

  assign misalign = misalign_q;
  assign empty    = q_empty && (state_q == IDLE);

  always_comb begin
    state_d            = state_q;
    pop                = 1'b0;
    mem.mem_r_op       = 1'b0;
    mem.mem_r_addr     = '0;
    mem.mem_w_op       = 1'b0;
    mem.mem_w_mem_addr = '0;
    mem.mem_w_mem_val  = '0;
    mem.mem_w_mem_be   = '0;
    case (state_q)
      IDLE: begin
        if (!q_empty) state_d = (USE_BE != 0) ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        mem.mem_r_op   = 1'b1;
        mem.mem_r_addr = head.addr;
        if (mem.mem_r_ack) state_d = WR_REQ;
      end
      WR_REQ: begin
        mem.mem_w_op       = 1'b1;
        mem.mem_w_mem_addr = head.addr;
        mem.mem_w_mem_val  = (USE_BE != 0) ? head.dat : merged_q;
        mem.mem_w_mem_be   = (USE_BE != 0) ? head.be : '1;
        if (mem.mem_w_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ins_exec_store_unit.sv
// Directed bench: RMW (32-bit), byte-enable (32-bit) and byte-enable (64-bit) instances.
module tb_ins_exec_store_unit;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  dec_op = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
  logic        a_op = 1'b0, b_op = 1'b0, c_op = 1'b0;
  logic [63:0] c_rs1 = '0, c_rs2 = '0, c_imm = '0;
  logic        a_ready, a_mis, a_empty;
  logic        b_ready, b_mis, b_empty;
  logic        c_ready, c_mis, c_empty;

  int n_pass  = 0;
  int n_total = 0;

  ins_exec_store_unit_if #(.XLEN(32)) if_a ();
  ins_exec_store_unit_if #(.XLEN(32)) if_b ();
  ins_exec_store_unit_if #(.XLEN(64)) if_c ();

  ins_exec_store_unit #(.XLEN(32), .DEPTH(4), .USE_BE(0)) u_rmw (
    .clk(clk), .rst(rst), .op(a_op), .ins_dec_op(dec_op), .ins_dec_funct3(f3),
    .reg_rs1_val(rs1), .reg_rs2_val(rs2), .imm_ext_ext(imm),
    .ready(a_ready), .misalign(a_mis), .empty(a_empty), .mem(if_a)
  );

  ins_exec_store_unit #(.XLEN(32), .DEPTH(4), .USE_BE(1)) u_be (
    .clk(clk), .rst(rst), .op(b_op), .ins_dec_op(dec_op), .ins_dec_funct3(f3),
    .reg_rs1_val(rs1), .reg_rs2_val(rs2), .imm_ext_ext(imm),
    .ready(b_ready), .misalign(b_mis), .empty(b_empty), .mem(if_b)
  );

  ins_exec_store_unit #(.XLEN(64), .DEPTH(4), .USE_BE(1)) u_be64 (
    .clk(clk), .rst(rst), .op(c_op), .ins_dec_op(dec_op), .ins_dec_funct3(f3),
    .reg_rs1_val(c_rs1), .reg_rs2_val(c_rs2), .imm_ext_ext(c_imm),
    .ready(c_ready), .misalign(c_mis), .empty(c_empty), .mem(if_c)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_b_write(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (if_b.mem_w_op) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    bit stray;

    if_a.mem_r_ack = 0; if_a.mem_r_val = '0; if_a.mem_w_ack = 0;
    if_b.mem_r_ack = 0; if_b.mem_r_val = '0; if_b.mem_w_ack = 0;
    if_c.mem_r_ack = 0; if_c.mem_r_val = '0; if_c.mem_w_ack = 0;
    dec_op = OP_ST;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", a_ready, 1);
    check("rst_empty", a_empty, 1);
    check("rst_misalign", a_mis, 0);
    check("rst_r_op", if_a.mem_r_op, 0);
    check("rst_w_op", if_a.mem_w_op, 0);
    check("rst_be_ready", b_ready, 1);
    check("rst_64_empty", c_empty, 1);

    // RMW SB at 0x1003
    f3 = 3'd0; rs1 = 32'h1000; imm = 32'd3; rs2 = 32'hAABBCCDD; a_op = 1'b1;
    tick();
    a_op = 1'b0;
    check("sb_n1_r_op", if_a.mem_r_op, 0);
    tick();
    check("sb_n2_r_op", if_a.mem_r_op, 1);
    check("sb_r_addr", if_a.mem_r_addr, 32'h1000);
    check("sb_n2_w_op", if_a.mem_w_op, 0);
    tick();
    check("sb_r_hold", if_a.mem_r_op, 1);
    if_a.mem_r_ack = 1'b1; if_a.mem_r_val = 32'h11223344;
    tick();
    if_a.mem_r_ack = 1'b0;
    check("sb_r_drop", if_a.mem_r_op, 0);
    check("sb_w_op", if_a.mem_w_op, 1);
    check("sb_w_addr", if_a.mem_w_mem_addr, 32'h1000);
    check("sb_w_val", if_a.mem_w_mem_val, 32'hDD223344);
    check("sb_w_be", if_a.mem_w_mem_be, 4'hF);
    if_a.mem_w_ack = 1'b1;
    tick();
    if_a.mem_w_ack = 1'b0;
    check("sb_w_done", if_a.mem_w_op, 0);
    check("sb_empty", a_empty, 1);

    // Byte-enable SH at 0x2002
    f3 = 3'd1; rs1 = 32'h2000; imm = 32'd2; rs2 = 32'h00001234; b_op = 1'b1;
    tick();
    b_op = 1'b0;
    check("sh_n1_w_op", if_b.mem_w_op, 0);
    tick();
    check("sh_n2_w_op", if_b.mem_w_op, 1);
    check("sh_r_op", if_b.mem_r_op, 0);
    check("sh_w_addr", if_b.mem_w_mem_addr, 32'h2000);
    check("sh_w_val", if_b.mem_w_mem_val, 32'h12340000);
    check("sh_w_be", if_b.mem_w_mem_be, 4'b1100);
    if_b.mem_w_ack = 1'b1;
    tick();
    if_b.mem_w_ack = 1'b0;
    check("sh_empty", b_empty, 1);

    // Misaligned SW at 0x3002 on the RMW unit
    f3 = 3'd2; rs1 = 32'h3000; imm = 32'd2; rs2 = 32'hCAFEF00D; a_op = 1'b1;
    tick();
    a_op = 1'b0;
    check("mis_n1", a_mis, 1);
    check("mis_n1_empty", a_empty, 1);
    tick();
    check("mis_n2", a_mis, 0);
    check("mis_n2_r_op", if_a.mem_r_op, 0);
    check("mis_n2_w_op", if_a.mem_w_op, 0);
    check("mis_n2_empty", a_empty, 1);

    // Unsupported funct3 and SD on a 32-bit unit are ignored
    f3 = 3'd4; rs1 = 32'h3001; imm = 32'd0; a_op = 1'b1;
    tick();
    f3 = 3'd3;
    tick();
    a_op = 1'b0;
    check("f3_4_misalign", a_mis, 0);
    check("f3_3_empty", a_empty, 1);
    tick();
    check("f3_ignored_misalign", a_mis, 0);
    check("f3_ignored_r_op", if_a.mem_r_op, 0);
    check("f3_ignored_empty", a_empty, 1);

    // Fill the byte-enable queue with the write ack held low
    f3 = 3'd2; imm = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rs1 = 32'h100 + 32'(4 * i); rs2 = 32'(i + 1); b_op = 1'b1;
      check("fill_ready", b_ready, 1);
      tick();
    end
    check("full_ready", b_ready, 0);
    rs1 = 32'h110; rs2 = 32'd5;
    tick();
    check("full_refuse_ready", b_ready, 0);
    check("full_head_w_op", if_b.mem_w_op, 1);
    check("full_head_addr", if_b.mem_w_mem_addr, 32'h100);
    check("full_head_val", if_b.mem_w_mem_val, 32'd1);
    if_b.mem_w_ack = 1'b1;
    check("pop_cycle_ready", b_ready, 0);
    tick();
    if_b.mem_w_ack = 1'b0;
    check("after_pop_ready", b_ready, 1);
    tick();
    b_op = 1'b0;
    check("fifth_taken_ready", b_ready, 0);
    for (int j = 1; j < 5; j++) begin
      wait_b_write(seen);
      check("drain_w_op_seen", seen, 1);
      check("drain_addr", if_b.mem_w_mem_addr, 32'h100 + 32'(4 * j));
      check("drain_val", if_b.mem_w_mem_val, 32'(j + 1));
      check("drain_be", if_b.mem_w_mem_be, 4'hF);
      if_b.mem_w_ack = 1'b1;
      tick();
      if_b.mem_w_ack = 1'b0;
    end
    check("drain_empty", b_empty, 1);

    // 64-bit SD at 0x4008
    f3 = 3'd3; c_rs1 = 64'h4000; c_imm = 64'd8; c_rs2 = 64'h0123456789ABCDEF; c_op = 1'b1;
    tick();
    c_op = 1'b0;
    check("sd_n1_mis", c_mis, 0);
    tick();
    check("sd_w_op", if_c.mem_w_op, 1);
    check("sd_w_addr", if_c.mem_w_mem_addr, 64'h4008);
    check("sd_w_val", if_c.mem_w_mem_val, 64'h0123456789ABCDEF);
    check("sd_w_be", if_c.mem_w_mem_be, 8'hFF);
    if_c.mem_w_ack = 1'b1;
    tick();
    if_c.mem_w_ack = 1'b0;

    // 64-bit SW at 0x4004 lands in the upper half
    f3 = 3'd2; c_imm = 64'd4; c_op = 1'b1;
    tick();
    c_op = 1'b0;
    tick();
    check("sw64_w_op", if_c.mem_w_op, 1);
    check("sw64_w_addr", if_c.mem_w_mem_addr, 64'h4000);
    check("sw64_w_val", if_c.mem_w_mem_val, 64'h89ABCDEF00000000);
    check("sw64_w_be", if_c.mem_w_mem_be, 8'hF0);
    if_c.mem_w_ack = 1'b1;
    tick();
    if_c.mem_w_ack = 1'b0;

    // 64-bit SD at 0x4004 is misaligned
    f3 = 3'd3; c_op = 1'b1;
    tick();
    c_op = 1'b0;
    check("sd64_mis", c_mis, 1);
    tick();
    check("sd64_mis_w_op", if_c.mem_w_op, 0);
    check("sd64_mis_empty", c_empty, 1);

    // Reset while the RMW unit sits in RD_REQ with two entries queued
    f3 = 3'd0; imm = 32'd0; rs2 = 32'h55; rs1 = 32'h1000; a_op = 1'b1;
    tick();
    rs1 = 32'h1004;
    tick();
    a_op = 1'b0;
    check("rst_mid_r_op_before", if_a.mem_r_op, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_r_op", if_a.mem_r_op, 0);
    check("rst_mid_empty", a_empty, 1);
    check("rst_mid_ready", a_ready, 1);
    stray = 1'b0;
    if_a.mem_r_ack = 1'b1; if_a.mem_w_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (if_a.mem_r_op || if_a.mem_w_op) stray = 1'b1;
      tick();
    end
    if_a.mem_r_ack = 1'b0; if_a.mem_w_ack = 1'b0;
    check("rst_mid_no_traffic", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ins_exec_store_unit.md
Name: ins_exec_store_unit

Overview:
- Parametrised successor to the combinational RV32I store executor.
- Decodes STORE instructions (SB/SH/SW, plus SD when XLEN=64) and computes the effective address and byte lanes, with alignment checking.
- Queues stores in a DEPTH-entry buffer and drains them to memory through a request/ack handshake.
- Drain mode is either read-modify-write or native byte-enable. The unit sits between the decode/regfile stage and the data memory port.

Parameters:
XLEN, 32, datapath/address width; legal values 32 or 64
DEPTH, 4, store-queue entries; power of two, at least 2
USE_BE, 0, 1 = memory accepts byte enables (no read phase); 0 = read-modify-write

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op  in  1  issue valid
ins_dec_op  in  7  decoded opcode
ins_dec_funct3  in  3  decoded funct3
reg_rs1_val  in  XLEN  base register
reg_rs2_val  in  XLEN  store data register
imm_ext_ext  in  XLEN  sign-extended S-immediate
ready  out  1  queue can accept a store this cycle
misalign  out  1  one-cycle pulse: rejected misaligned store
empty  out  1  queue empty and FSM idle (fence/drain indicator)
mem_r_op  out  1  read request (RMW only)
mem_r_addr  out  XLEN  word-aligned read address
mem_r_ack  in  1  read data valid
mem_r_val  in  XLEN  read data
mem_w_op  out  1  write request
mem_w_mem_addr  out  XLEN  word-aligned write address
mem_w_mem_val  out  XLEN  write data
mem_w_mem_be  out  XLEN/8  byte enables
mem_w_ack  in  1  write accepted

Behaviour:
- Reset values:
  - Queue emptied and FSM in IDLE.
  - ready=1, empty=1, misalign=0.
  - All mem_* outputs 0.
- Reset mid-transaction abandons the in-flight request: outputs read 0 in the cycle after reset.
- Store detection: op=1, ins_dec_op=7'b0100011, and funct3 in {0,1,2}, or {0,1,2,3} when XLEN=64. Other funct3 values are ignored (no enqueue, no misalign).
- Address computation:
  - addr = rs1 + imm, modulo 2^XLEN.
  - off = addr[log2(XLEN/8)-1:0].
  - Word address = addr with the off bits cleared.
- Alignment: misaligned if SH has off[0]≠0, SW has off[1:0]≠0, or SD has off[2:0]≠0.
  - A misaligned store is not enqueued.
  - misalign is registered and pulses exactly one cycle after the issue cycle.
- Queue entry fields:
  - word address;
  - data = rs2 low bytes shifted left by 8*off;
  - be = size mask (1, 3, 0xF or 0xFF) shifted left by off.
- Enqueue:
  - Occurs on an aligned store when ready=1.
  - ready = (count != DEPTH), derived from the registered count only; there is no same-cycle pop bypass.
  - If ready=0 the store is not accepted; the issuer must hold op.
- Drain FSM:
  - IDLE: if count≠0, go to WR_REQ when USE_BE=1, else to RD_REQ.
  - RD_REQ: mem_r_op=1 and mem_r_addr=head address, both held until mem_r_ack.
    - On ack, latch merged = (mem_r_val & ~lanemask) | (data & lanemask), where lanemask expands be to bits.
    - Then go to WR_REQ.
  - WR_REQ: mem_w_op=1 with address, value and be held stable until mem_w_ack.
    - Write value is the entry data when USE_BE=1, else the merged word.
    - be is the entry be when USE_BE=1, else all ones.
    - On ack, pop the head and go to IDLE.
- Latency: a store issued in cycle N sees mem_w_op (BE mode) or mem_r_op (RMW mode) first asserted in cycle N+2.
- Simultaneous events: enqueue and pop in the same cycle leave count unchanged; a full queue plus a pop does not raise ready until the next cycle.
- Pointer wrap: pointers wrap modulo DEPTH, with count tracked separately.
- Idle outputs: mem_* outputs are 0 whenever not asserted.
- empty = (count==0) and FSM in IDLE.

Decomposition:
- Shared package:
  - OPCODE_STORE constant;
  - FUNCT3_SB/SH/SW/SD constants;
  - drain-state enum {IDLE, RD_REQ, WR_REQ};
  - size-mask function.
- One sub-module: store_queue_fifo, a generic synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty, head.
  - Entry width = XLEN + XLEN + XLEN/8.

Test Plan:
- XLEN=32, USE_BE=0: SB with rs1=0x1000, imm=3, rs2=0xAABBCCDD; mem_r_val=0x11223344 → mem_r_addr=0x1000, then a write of 0xDD223344 with be=4'hF.
- USE_BE=1: SH with rs1=0x2000, imm=2, rs2=0x00001234 → no read; write addr=0x2000, val=0x12340000, be=4'b1100 in cycle N+2.
- SW with rs1=0x3000, imm=2 → misalign=1 in cycle N+1 only; no mem_r_op/mem_w_op; empty stays 1.
- DEPTH=4, mem_w_ack held 0: issue 4 SW → ready=0 after the 4th and a 5th store is refused. Then pulse ack for one cycle → ready=1 next cycle, and the 5th is accepted. Writes emerge in program order.
- XLEN=64: SD with addr=0x4008, rs2=0x0123456789ABCDEF → be=8'hFF, val unchanged. SW at 0x4004 → be=8'hF0, data in bits 63:32.
- Assert rst while in RD_REQ with 2 entries queued → next cycle mem_r_op=0, empty=1, ready=1, and no write is ever issued.
